// File: rtl/core_seq_ctrl.sv
// Multi-cycle RV64 sequencer: 4 cycles per plain instruction, 5 per load-store with zero-wait memory.
// Fetch/data requests are held until the memory answers or the wait counter expires into an error halt.
module core_seq_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'h8000_0000,
  parameter int          MEM_TIMEOUT = 16,
  parameter int          CNT_W       = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [63:0]      pc,
  output logic             imem_req,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      inst,
  input  logic [4:0]       inst_type,
  input  logic             rd_w_ena_i,
  input  logic [63:0]      pc_next,
  output logic             dmem_req,
  input  logic             dmem_ready,
  output logic             rf_w_ena,
  output logic             halt,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            st_q, st_d;
  logic [WAIT_W-1:0] wait_q;
  logic              wait_inc, wait_clr, err_set, retire, load_inst, load_pc;
  logic              pc_next_unused;

  // Fetch targets are word aligned; the low PC bits from execute are dropped.
  assign pc_next_unused = ^pc_next[1:0];

  always_comb begin
    st_d      = st_q;
    wait_inc  = 1'b0;
    wait_clr  = 1'b0;
    err_set   = 1'b0;
    retire    = 1'b0;
    load_inst = 1'b0;
    load_pc   = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    rf_w_ena  = 1'b0;
    case (st_q)
      S_IDLE: if (start) st_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          load_inst = 1'b1;
          wait_clr  = 1'b1;
          st_d      = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          wait_clr = 1'b1;
          err_set  = 1'b1;
          st_d     = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (inst_type == 5'd0) begin
          err_set = 1'b1;
          st_d    = S_HALT;
        end else if (inst_type[0]) begin
          retire = 1'b1;
          st_d   = S_HALT;
        end else begin
          st_d = S_EXEC;
        end
      end
      S_EXEC: st_d = inst_type[2] ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          wait_clr = 1'b1;
          st_d     = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          wait_clr = 1'b1;
          err_set  = 1'b1;
          st_d     = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        rf_w_ena = rd_w_ena_i;
        load_pc  = 1'b1;
        retire   = 1'b1;
        st_d     = S_FETCH;
      end
      S_HALT: st_d = S_HALT;
      default: begin
        err_set = 1'b1;
        st_d    = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= S_IDLE;
    else      st_q <= st_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      inst      <= 32'd0;
      err       <= 1'b0;
      wait_q    <= '0;
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      if (err_set)   err  <= 1'b1;
      if (load_inst) inst <= imem_rdata;
      if (load_pc)   pc   <= {pc_next[63:2], 2'b00};
      if (wait_clr)      wait_q <= '0;
      else if (wait_inc) wait_q <= wait_q + WAIT_W'(1);
      if (retire) instret <= instret + CNT_W'(1);
      if (st_q != S_IDLE && st_q != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  assign halt  = (st_q == S_HALT);
  assign state = st_q;

endmodule
